// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SA_WIDTH = 8;

endpackage : serial_add_pkg

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Combinational full adder: two NAND-level half adders plus an OR of their
// carries. One instance is time-shared across all operand bits.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic h1_n1_s, h1_n2_s, h1_n3_s, h1_s_s, h1_c_s;
  logic h2_n1_s, h2_n2_s, h2_n3_s, h2_c_s;

  // Half adder 1: the four-NAND XOR, with the carry taken from the shared first NAND
  assign h1_n1_s = ~(a_i & b_i);
  assign h1_n2_s = ~(a_i & h1_n1_s);
  assign h1_n3_s = ~(b_i & h1_n1_s);
  assign h1_s_s  = ~(h1_n2_s & h1_n3_s);
  assign h1_c_s  = ~h1_n1_s;

  assign h2_n1_s = ~(h1_s_s & c_i);
  assign h2_n2_s = ~(h1_s_s & h2_n1_s);
  assign h2_n3_s = ~(c_i & h2_n1_s);
  assign s_o     = ~(h2_n2_s & h2_n3_s);
  assign h2_c_s  = ~h2_n1_s;

  assign c_o = h1_c_s | h2_c_s;

endmodule : fa_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: runs one fa_cell over WIDTH operand bits, LSB
// first, framed by start/done. Define SERIAL_ADD_SUB_EN for the sub (a-b) mode.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // Only WIDTH-1 result bits are stored; the cell's last sum bit completes the word
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             b_bit_s, cin_start_s;
  logic             fa_s_s, fa_c_s;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;

  assign b_bit_s     = b_sr_q[0] ^ sub_q;
  assign cin_start_s = sub;
`else
  assign b_bit_s     = b_sr_q[0];
  assign cin_start_s = 1'b0;
`endif

  fa_cell u_fa (
    .a_i (a_sr_q[0]),
    .b_i (b_bit_s),
    .c_i (cy_q),
    .s_o (fa_s_s),
    .c_o (fa_c_s)
  );

  // Next-state, datapath shift and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    cy_d     = cy_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
`ifdef SERIAL_ADD_SUB_EN
    sub_d    = sub_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          cy_d    = cin_start_s;
          cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = sub;
`endif
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cy_d     = fa_c_s;
        res_sr_d = (WIDTH-1)'({fa_s_s, res_sr_q} >> 1);
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          sum_d   = {fa_s_s, res_sr_q};
          carry_d = fa_c_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      cy_q     <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      cy_q     <= cy_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: the driver models acceptance and
// pushes expected results; a negedge monitor pops and checks every cycle.
module tb_serial_adder_ctrl;
  import serial_add_pkg::*;

  localparam int W = SA_WIDTH;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         sub;
  logic         busy, done, carry;
  logic [W-1:0] sum;

  exp_t         q[$];
  int           edge_n  = 0;
  int           next_ok = 0;
  int           total   = 0;
  int           bad     = 0;
  logic [W-1:0] hold_s  = '0;
  logic         hold_c  = 1'b0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    longint r;
    if (s) r = longint'(x) + (longint'(1) << W) - longint'(y);
    else   r = longint'(x) + longint'(y);
    return r[W:0];
  endfunction

  // One clock: drive inputs, then decide from the bench's own timeline whether start is taken
  task automatic tick(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic sv);
    logic       eff_sub;
    logic [W:0] r;
    exp_t       e;
    start = st; a = av; b = bv; sub = sv;
    @(posedge clk);
    #1;
    edge_n++;
`ifdef SERIAL_ADD_SUB_EN
    eff_sub = sv;
`else
    eff_sub = 1'b0;
`endif
    if (!rst && st && edge_n >= next_ok) begin
      r     = model(av, bv, eff_sub);
      e.s   = r[W-1:0];
      e.c   = r[W];
      e.due = edge_n + W;
      q.push_back(e);
      next_ok = edge_n + W + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, W'($urandom), W'($urandom), 1'b0);
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    tick(1'b1, av, bv, sv);
    idle(W + 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    q.delete();
    next_ok = 0;
    idle(n);
    rst = 1'b0;
  endtask

  // Monitor: busy/done every cycle, result on done, held result otherwise
  always @(negedge clk) begin
    logic busy_exp, done_exp;
    exp_t e;
    busy_exp = !rst && (edge_n < next_ok - 1);
    done_exp = !rst && (q.size() > 0) && (q[0].due == edge_n);
    total++;
    if (busy !== busy_exp) begin
      bad++;
      $display("FAIL busy edge=%0d got=%b want=%b", edge_n, busy, busy_exp);
    end
    total++;
    if (done !== done_exp) begin
      bad++;
      $display("FAIL done edge=%0d got=%b want=%b", edge_n, done, done_exp);
    end
    if (rst) begin
      hold_s = '0;
      hold_c = 1'b0;
    end
    if (done_exp) begin
      e = q.pop_front();
      hold_s = e.s;
      hold_c = e.c;
    end
    total++;
    if (sum !== hold_s || carry !== hold_c) begin
      bad++;
      $display("FAIL result edge=%0d got=%h/%b want=%h/%b", edge_n, sum, carry, hold_s, hold_c);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(2);

    op(8'h00, 8'h00, 1'b0);
    idle(2);
    op(8'hFF, 8'h01, 1'b0);
    op(8'hA5, 8'h5A, 1'b0);

    // Start arriving mid-run must be ignored
    tick(1'b1, 8'h12, 8'h34, 1'b0);
    idle(2);
    tick(1'b1, 8'hFF, 8'hFF, 1'b0);
    idle(W - 1);
    idle(3);

    // Abort mid-run, then a clean operation
    tick(1'b1, 8'h55, 8'h66, 1'b0);
    idle(4);
    do_reset(2);
    op(8'h01, 8'h01, 1'b0);

    // Start held high: back-to-back accepts
    for (int i = 0; i < 2 * (W + 2) + 3; i++) tick(1'b1, W'($urandom), W'($urandom), 1'b0);
    idle(W + 2);

    // Reset released with start already high
    rst = 1'b1;
    q.delete();
    next_ok = 0;
    tick(1'b1, 8'h33, 8'h44, 1'b0);
    rst = 1'b0;
    tick(1'b1, 8'h70, 8'h90, 1'b0);
    idle(W + 2);

`ifdef SERIAL_ADD_SUB_EN
    op(8'h05, 8'h07, 1'b1);
    op(8'h07, 8'h05, 1'b1);
    op(8'h80, 8'h80, 1'b1);
`endif

    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom), 1'($urandom));
    idle(W + 3);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_adder_ctrl
